// File: rtl/rx_cmd_decoder.sv
// -----------------------------------------------------------------------------
// rx_cmd_decoder
//
// Purpose:
//   Assembles command frames from the UART receive byte stream and issues
//   one-cycle strobes to the register file and the ALU.
//   Frames:
//     OP_WR      addr data   -> wr_en with addr/wr_data
//     OP_RD      addr        -> rd_en with addr
//     OP_ALU_OPS a b fun     -> wr_en (addr 0, a), wr_en (addr 1, b), alu_en
//     OP_ALU_NOP fun         -> alu_en
//   Bytes inside a frame are payload; they are never decoded as opcodes.
//
// Optional feature (macro RX_CMD_TIMEOUT_EN):
//   When defined, a partial frame that sees no byte for TIMEOUT cycles is
//   aborted: the FSM returns to IDLE, cmd_err pulses and alu_clk_en clears.
//   When undefined, a partial frame waits indefinitely.
//
// Ports:
//   clk        in   system clock (UART RX clock domain)
//   rst        in   asynchronous active-high reset
//   rx_data    in   received byte
//   rx_valid   in   one-cycle byte strobe
//   wr_en      out  register-file write strobe (one cycle)
//   rd_en      out  register-file read strobe (one cycle)
//   addr       out  register-file address (holds between strobes)
//   wr_data    out  register-file write data (holds between strobes)
//   alu_en     out  ALU execute strobe (one cycle)
//   alu_fun    out  ALU function code (holds between strobes)
//   alu_clk_en out  ALU clock-gate enable, opcode byte through alu_en cycle
//   busy       out  high while a frame is partially received
//   cmd_err    out  one-cycle strobe on unknown opcode or timeout abort
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module rx_cmd_decoder #(
   parameter int         ADDR_W     = 4,
   parameter logic [7:0] OP_WR      = 8'hAA,
   parameter logic [7:0] OP_RD      = 8'hBB,
   parameter logic [7:0] OP_ALU_OPS = 8'hCC,
   parameter logic [7:0] OP_ALU_NOP = 8'hDD,
   parameter int         TIMEOUT    = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              wr_en,
   output logic              rd_en,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        wr_data,
   output logic              alu_en,
   output logic [3:0]        alu_fun,
   output logic              alu_clk_en,
   output logic              busy,
   output logic              cmd_err
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      RD_ADDR = 3'd3,
      ALU_A   = 3'd4,
      ALU_B   = 3'd5,
      ALU_FUN = 3'd6
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;

   logic                wr_en_nxt_s;
   logic                rd_en_nxt_s;
   logic                alu_en_nxt_s;
   logic                cmd_err_nxt_s;
   logic                alu_clk_en_nxt_s;
   logic [ADDR_W-1:0]   addr_nxt_s;
   logic [7:0]          wr_data_nxt_s;
   logic [3:0]          alu_fun_nxt_s;

`ifdef RX_CMD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // Last count value before the abort fires; a frame idles TIMEOUT cycles.
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0]    to_cnt_r;
   logic [CNT_W-1:0]    to_cnt_nxt_s;
`else
   // TIMEOUT is only meaningful with the watchdog compiled in; this empty
   // generate keeps the parameter referenced in the default build.
   if (TIMEOUT < 2) begin : g_timeout_unused
   end
`endif

   // Next-state and next-output decode for one received byte (or idle cycle).
   always_comb begin
      state_nxt_s      = state_r;
      wr_en_nxt_s      = 1'b0;
      rd_en_nxt_s      = 1'b0;
      alu_en_nxt_s     = 1'b0;
      cmd_err_nxt_s    = 1'b0;
      addr_nxt_s       = addr;
      wr_data_nxt_s    = wr_data;
      alu_fun_nxt_s    = alu_fun;
      // The clock gate stays open through the alu_en cycle and closes after.
      alu_clk_en_nxt_s = alu_en ? 1'b0 : alu_clk_en;
`ifdef RX_CMD_TIMEOUT_EN
      to_cnt_nxt_s     = to_cnt_r;
`endif

      if (rx_valid) begin
`ifdef RX_CMD_TIMEOUT_EN
         // A byte always wins over an expiring counter.
         to_cnt_nxt_s = {CNT_W{1'b0}};
`endif
         case (state_r)
            IDLE: begin
               if (rx_data == OP_WR) begin
                  state_nxt_s = WR_ADDR;
               end else if (rx_data == OP_RD) begin
                  state_nxt_s = RD_ADDR;
               end else if (rx_data == OP_ALU_OPS) begin
                  state_nxt_s      = ALU_A;
                  alu_clk_en_nxt_s = 1'b1;
               end else if (rx_data == OP_ALU_NOP) begin
                  state_nxt_s      = ALU_FUN;
                  alu_clk_en_nxt_s = 1'b1;
               end else begin
                  state_nxt_s   = IDLE;
                  cmd_err_nxt_s = 1'b1;
               end
            end
            WR_ADDR: begin
               addr_nxt_s  = rx_data[ADDR_W-1:0];
               state_nxt_s = WR_DATA;
            end
            WR_DATA: begin
               wr_data_nxt_s = rx_data;
               wr_en_nxt_s   = 1'b1;
               state_nxt_s   = IDLE;
            end
            RD_ADDR: begin
               addr_nxt_s  = rx_data[ADDR_W-1:0];
               rd_en_nxt_s = 1'b1;
               state_nxt_s = IDLE;
            end
            ALU_A: begin
               // Operand A lands in register 0.
               addr_nxt_s    = {ADDR_W{1'b0}};
               wr_data_nxt_s = rx_data;
               wr_en_nxt_s   = 1'b1;
               state_nxt_s   = ALU_B;
            end
            ALU_B: begin
               // Operand B lands in register 1.
               addr_nxt_s    = ADDR_W'(1);
               wr_data_nxt_s = rx_data;
               wr_en_nxt_s   = 1'b1;
               state_nxt_s   = ALU_FUN;
            end
            ALU_FUN: begin
               alu_fun_nxt_s    = rx_data[3:0];
               alu_en_nxt_s     = 1'b1;
               alu_clk_en_nxt_s = 1'b1;
               state_nxt_s      = IDLE;
            end
            default: begin
               state_nxt_s      = IDLE;
               alu_clk_en_nxt_s = 1'b0;
            end
         endcase
      end else begin
`ifdef RX_CMD_TIMEOUT_EN
         if (state_r != IDLE) begin
            if (to_cnt_r == TO_LAST) begin
               state_nxt_s      = IDLE;
               cmd_err_nxt_s    = 1'b1;
               alu_clk_en_nxt_s = 1'b0;
               to_cnt_nxt_s     = {CNT_W{1'b0}};
            end else begin
               to_cnt_nxt_s = to_cnt_r + CNT_W'(1);
            end
         end else begin
            to_cnt_nxt_s = {CNT_W{1'b0}};
         end
`else
         // No byte: state and held outputs stay as they are.
         state_nxt_s = state_r;
`endif
      end
   end

   // State and output registers; reset drops any partial frame silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         wr_en      <= 1'b0;
         rd_en      <= 1'b0;
         alu_en     <= 1'b0;
         cmd_err    <= 1'b0;
         alu_clk_en <= 1'b0;
         busy       <= 1'b0;
         addr       <= {ADDR_W{1'b0}};
         wr_data    <= 8'h00;
         alu_fun    <= 4'h0;
      end else begin
         state_r    <= state_nxt_s;
         wr_en      <= wr_en_nxt_s;
         rd_en      <= rd_en_nxt_s;
         alu_en     <= alu_en_nxt_s;
         cmd_err    <= cmd_err_nxt_s;
         alu_clk_en <= alu_clk_en_nxt_s;
         busy       <= (state_nxt_s != IDLE);
         addr       <= addr_nxt_s;
         wr_data    <= wr_data_nxt_s;
         alu_fun    <= alu_fun_nxt_s;
      end
   end

`ifdef RX_CMD_TIMEOUT_EN
   // Idle-cycle counter for the partial-frame watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_r <= {CNT_W{1'b0}};
      end else begin
         to_cnt_r <= to_cnt_nxt_s;
      end
   end
`endif

endmodule

// File: doc/rx_cmd_decoder.md
Name: rx_cmd_decoder

Overview:
- Consumes the byte stream produced by the UART receiver (p_data/data_valid) and assembles multi-byte command frames.
- Frames are register-file write, register-file read, ALU-with-operands and ALU-without-operands.
- Issues single-cycle register-file and ALU strobes to the system datapath.
- Single clock domain (UART RX clock); sits between uart_rx and the register file / ALU.

Parameters:
- ADDR_W, 4, register-file address width; taken from the low ADDR_W bits of the address byte.
- OP_WR, 8'hAA, opcode for a register write frame.
- OP_RD, 8'hBB, opcode for a register read frame.
- OP_ALU_OPS, 8'hCC, opcode for an ALU command with two operand bytes.
- OP_ALU_NOP, 8'hDD, opcode for an ALU command without operands.
- TIMEOUT, 4096, idle cycles before a partial frame aborts (only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte (uart_rx p_data).
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- wr_en  out  1  register-file write strobe, one cycle.
- rd_en  out  1  register-file read strobe, one cycle.
- addr  out  ADDR_W  register-file address.
- wr_data  out  8  register-file write data.
- alu_en  out  1  ALU execute strobe, one cycle.
- alu_fun  out  4  ALU function code.
- alu_clk_en  out  1  ALU clock-gate enable.
- busy  out  1  high while a frame is partially received.
- cmd_err  out  1  one-cycle strobe on an unknown opcode or a timeout abort.

Behaviour:
- Reset: asynchronous, active-high. All outputs go to 0 and the FSM goes to IDLE. A reset mid-frame discards the frame with no strobes.
- Timing: all outputs are registered. A strobe caused by a byte is high for exactly the one cycle after the rising edge that samples rx_valid=1. With rx_valid low, FSM and outputs hold; strobes return to 0.
- busy = (state != IDLE), registered.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN.
- IDLE:
  - byte OP_WR -> WR_ADDR.
  - byte OP_RD -> RD_ADDR.
  - byte OP_ALU_OPS -> ALU_A, alu_clk_en set.
  - byte OP_ALU_NOP -> ALU_FUN, alu_clk_en set.
  - any other byte -> cmd_err pulse, stay IDLE.
- WR_ADDR: addr register <= byte[ADDR_W-1:0] -> WR_DATA.
- WR_DATA: wr_data <= byte, wr_en pulse with the stored addr -> IDLE.
- RD_ADDR: addr <= byte[ADDR_W-1:0], rd_en pulse -> IDLE.
- ALU_A: operand A written to address 0 (addr=0, wr_data=byte, wr_en pulse) -> ALU_B.
- ALU_B: operand B written to address 1 (addr=1, wr_data=byte, wr_en pulse) -> ALU_FUN.
- ALU_FUN: alu_fun <= byte[3:0], alu_en pulse -> IDLE. Upper nibble ignored.
- alu_clk_en: stays high from the opcode byte through the alu_en cycle, and clears the cycle after alu_en. It is also cleared on an abort or reset.
- Hold after strobe: addr, wr_data and alu_fun keep their last values when no strobe is active.
- No special bytes mid-frame: opcode values received inside a frame are treated as payload, never re-decoded.
- Back-to-back bytes: rx_valid may be high on consecutive cycles. Every byte is consumed and no byte is dropped.

Optional Feature:
- Macro: RX_CMD_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on every rx_valid and increments each cycle while busy=1.
  - On reaching TIMEOUT-1 with no byte: FSM -> IDLE, cmd_err pulse, alu_clk_en cleared, no data strobes.
  - If rx_valid arrives in the same cycle the counter expires, the byte wins: it is processed normally and the counter clears.
- Not defined: no counter is built; a partial frame waits indefinitely for its next byte.

Test Plan:
- Write frame: bytes AA,05,3C -> one wr_en pulse with addr=5, wr_data=3C; busy high from after AA until after 3C; no other strobes.
- Read frame: bytes BB,17 (ADDR_W=4) -> one rd_en pulse with addr=7; cmd_err stays 0.
- ALU with operands, back-to-back on consecutive cycles: CC,10,20,F2 -> wr_en pulses (addr 0, data 10) then (addr 1, data 20), then alu_en with alu_fun=2; alu_clk_en high from after CC through the alu_en cycle.
- Bad and non-operand opcodes: byte 55 -> cmd_err pulse, stays IDLE; then DD,03 -> alu_en with alu_fun=3 and no wr_en.
- Reset mid-frame: AA,02 then rst asserted -> all outputs 0 immediately, no wr_en; after release, AA,02,11 -> wr_en with addr=2, wr_data=11.
- RX_CMD_TIMEOUT_EN defined, TIMEOUT=16: CC,01 then 16 idle cycles -> cmd_err pulse, busy=0, alu_clk_en=0; a following byte 01 -> cmd_err (unknown opcode).
